// File: rtl/mix_columns_seq.sv
// ---------------------------------------------------------------------------
// mix_columns_seq
//   Sequential AES MixColumns / InvMixColumns stage. It takes the 128-bit
//   ShiftRows output and transforms COLS_PER_CYCLE 32-bit columns per clock.
//   The finished state is presented to AddRoundKey with a valid/ready
//   handshake. When bypass is set, the state is passed through unchanged,
//   which is used for the final encryption round.
//
//   Parameters
//     COLS_PER_CYCLE  columns per clock (1, 2 or 4); NCYC = 4/COLS_PER_CYCLE
//
//   Ports
//     clk        in   1    rising-edge clock
//     rst        in   1    synchronous active-high reset
//     in_vld     in   1    state_in/inv/bypass valid
//     in_rdy     out  1    a state can be accepted this cycle
//     state_in   in   128  byte i = 4*col+row at bits [8i+7:8i]
//     inv        in   1    0 = MixColumns, 1 = InvMixColumns (latched at accept)
//     bypass     in   1    1 = pass the state through (latched at accept)
//     out_vld    out  1    state_out valid
//     out_rdy    in   1    downstream accepts state_out
//     state_out  out  128  result, same byte ordering as state_in
//     busy       out  1    high while calculating or holding a result
// ---------------------------------------------------------------------------
module mix_columns_seq #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_vld,
    output logic         in_rdy,
    input  logic [127:0] state_in,
    input  logic         inv,
    input  logic         bypass,
    output logic         out_vld,
    input  logic         out_rdy,
    output logic [127:0] state_out,
    output logic         busy
);

    localparam int NCYC = 4 / COLS_PER_CYCLE;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_HOLD} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [1:0]         r_cnt;
    logic [3:0][31:0]   r_work;
    logic               r_inv;
    logic [127:0]       r_out;

    logic               w_accept;
    logic               w_last;
    logic [3:0][31:0]   w_work_nxt;
    logic [1:0]         w_idx [COLS_PER_CYCLE];

    // GF(2^8) doubling with the AES reduction polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
    endfunction

    function automatic logic [7:0] mul3(input logic [7:0] a);
        return xtime(a) ^ a;
    endfunction

    // Inverse coefficients built from the x2/x4/x8 chain:
    // 9 = 8+1, 11 = 8+2+1, 13 = 8+4+1, 14 = 8+4+2.
    function automatic logic [7:0] mul9(input logic [7:0] a);
        return xtime(xtime(xtime(a))) ^ a;
    endfunction

    function automatic logic [7:0] mul11(input logic [7:0] a);
        return xtime(xtime(xtime(a))) ^ xtime(a) ^ a;
    endfunction

    function automatic logic [7:0] mul13(input logic [7:0] a);
        return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ a;
    endfunction

    function automatic logic [7:0] mul14(input logic [7:0] a);
        return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ xtime(a);
    endfunction

    // One column; byte 0 (row 0) is the least significant byte.
    function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv_mode);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] b0, b1, b2, b3;
        a0 = col[7:0];
        a1 = col[15:8];
        a2 = col[23:16];
        a3 = col[31:24];
        if (inv_mode) begin
            b0 = mul14(a0) ^ mul11(a1) ^ mul13(a2) ^ mul9(a3);
            b1 = mul14(a1) ^ mul11(a2) ^ mul13(a3) ^ mul9(a0);
            b2 = mul14(a2) ^ mul11(a3) ^ mul13(a0) ^ mul9(a1);
            b3 = mul14(a3) ^ mul11(a0) ^ mul13(a1) ^ mul9(a2);
        end else begin
            b0 = xtime(a0) ^ mul3(a1) ^ a2 ^ a3;
            b1 = xtime(a1) ^ mul3(a2) ^ a3 ^ a0;
            b2 = xtime(a2) ^ mul3(a3) ^ a0 ^ a1;
            b3 = xtime(a3) ^ mul3(a0) ^ a1 ^ a2;
        end
        return {b3, b2, b1, b0};
    endfunction

    assign w_accept = in_vld && in_rdy;
    assign w_last   = (r_cnt == 2'(NCYC - 1));

    // Column slice for this cycle: columns [cnt*C .. cnt*C+C-1] are mixed in place.
    always_comb begin
        w_work_nxt = r_work;
        for (int i = 0; i < COLS_PER_CYCLE; i++) begin
            w_idx[i] = 2'(int'(r_cnt) * COLS_PER_CYCLE + i);
            w_work_nxt[w_idx[i]] = mix_col(r_work[w_idx[i]], r_inv);
        end
    end

    // FSM next state and outputs.
    always_comb begin
        w_state_nxt = r_state;
        in_rdy      = 1'b0;
        out_vld     = 1'b0;
        busy        = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_rdy = 1'b1;
                if (in_vld) begin
                    w_state_nxt = bypass ? S_HOLD : S_CALC;
                end
            end
            S_CALC: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                busy    = 1'b1;
                out_vld = 1'b1;
                in_rdy  = out_rdy;
                if (out_rdy) begin
                    // Output retires; a waiting input is taken on the same edge.
                    if (in_vld) begin
                        w_state_nxt = bypass ? S_HOLD : S_CALC;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign state_out = r_out;

    // Control and output register: state_out only changes on entry to HOLD.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 2'd0;
            r_out   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_CALC) begin
                if (w_last) begin
                    r_cnt <= 2'd0;
                    r_out <= w_work_nxt;
                end else begin
                    r_cnt <= r_cnt + 2'd1;
                end
            end
            if (w_accept && bypass) begin
                r_out <= state_in;
            end
        end
    end

    // Working state: loaded at accept, mixed in place during CALC.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_work <= state_in;
            r_inv  <= inv;
        end else if (r_state == S_CALC) begin
            r_work <= w_work_nxt;
        end
    end

endmodule

// File: tb/tb_mix_columns_seq.sv
module tb_mix_columns_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         in_vld  [3];
    logic         in_rdy  [3];
    logic [127:0] st_in   [3];
    logic         inv_i   [3];
    logic         byp     [3];
    logic         out_vld [3];
    logic         out_rdy [3];
    logic [127:0] st_out  [3];
    logic         busy    [3];

    int checks = 0;
    int errors = 0;

    // Instance g uses COLS_PER_CYCLE = 1, 2, 4.
    for (genvar g = 0; g < 3; g++) begin : g_dut
        mix_columns_seq #(.COLS_PER_CYCLE(1 << g)) u_dut (
            .clk      (clk),
            .rst      (rst),
            .in_vld   (in_vld[g]),
            .in_rdy   (in_rdy[g]),
            .state_in (st_in[g]),
            .inv      (inv_i[g]),
            .bypass   (byp[g]),
            .out_vld  (out_vld[g]),
            .out_rdy  (out_rdy[g]),
            .state_out(st_out[g]),
            .busy     (busy[g])
        );
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Generic shift-and-add GF(2^8) multiply.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [127:0] ref_mix(input logic [127:0] s, input logic iv);
        logic [7:0]   k [4];
        logic [7:0]   acc;
        logic [127:0] o;
        if (iv) k = '{8'd14, 8'd11, 8'd13, 8'd9};
        else    k = '{8'd2, 8'd3, 8'd1, 8'd1};
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++) begin
                    acc = acc ^ gmul(s[(4*c + (r+j)%4)*8 +: 8], k[j]);
                end
                o[(4*c + r)*8 +: 8] = acc;
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inverse);
        logic [127:0] o;
        int src;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                src = inverse ? (c - r + 4) % 4 : (c + r) % 4;
                o[(4*c + r)*8 +: 8] = s[(4*src + r)*8 +: 8];
            end
        end
        return o;
    endfunction

    // One full transaction on instance d; input is scrambled after accept.
    task automatic xact(input int d, input logic [127:0] din, input logic iv, input logic bp,
                        output logic [127:0] dout, output int lat);
        int n;
        @(negedge clk);
        st_in[d]   = din;
        inv_i[d]   = iv;
        byp[d]     = bp;
        in_vld[d]  = 1'b1;
        out_rdy[d] = 1'b0;
        n = 0;
        while (!in_rdy[d] && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("accept_rdy", 128'(in_rdy[d]), 128'd1);
        @(posedge clk);
        #1;
        in_vld[d] = 1'b0;
        st_in[d]  = ~din;
        inv_i[d]  = ~iv;
        byp[d]    = ~bp;
        lat = 1;
        @(negedge clk);
        while (!out_vld[d] && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        dout = st_out[d];
        out_rdy[d] = 1'b1;
        @(negedge clk);
        out_rdy[d] = 1'b0;
    endtask

    typedef struct {
        logic [127:0] din;
        logic         iv;
        logic         bp;
        logic [127:0] exp;
    } vec_t;

    vec_t tbl [8];

    localparam logic [127:0] V_A  = 128'hc6c6c6c6_01010101_5c220af2_455313db;
    localparam logic [127:0] V_AM = 128'hc6c6c6c6_01010101_9d58dc9f_bca14d8e;
    localparam logic [127:0] V_B  = 128'h00000000_00000000_00000000_d5d4d4d4;
    localparam logic [127:0] V_BM = 128'h00000000_00000000_00000000_d6d7d5d5;
    localparam logic [127:0] V_C  = 128'h32211003312013023023120133221100;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [127:0] res, x, s, y, z;
        int lat, n;
        logic seen;

        tbl[0] = '{V_A,  1'b0, 1'b0, V_AM};
        tbl[1] = '{V_AM, 1'b1, 1'b0, V_A};
        tbl[2] = '{V_B,  1'b0, 1'b0, V_BM};
        tbl[3] = '{V_C,  1'b1, 1'b1, V_C};
        tbl[4] = '{V_AM, 1'b0, 1'b1, V_AM};
        tbl[5] = '{{128{1'b1}}, 1'b0, 1'b0, {128{1'b1}}};
        tbl[6] = '{{128{1'b1}}, 1'b1, 1'b0, {128{1'b1}}};
        tbl[7] = '{128'h0, 1'b0, 1'b0, 128'h0};

        for (int d = 0; d < 3; d++) begin
            in_vld[d] = 1'b0; st_in[d] = '0; inv_i[d] = 1'b0;
            byp[d] = 1'b0; out_rdy[d] = 1'b0;
        end

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int d = 0; d < 3; d++) begin
            check("rst_in_rdy",  128'(in_rdy[d]),  128'd1);
            check("rst_out_vld", 128'(out_vld[d]), 128'd0);
            check("rst_busy",    128'(busy[d]),    128'd0);
            check("rst_state_out", st_out[d], 128'd0);
        end

        // Directed vector table on every column width
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 8; i++) begin
                xact(d, tbl[i].din, tbl[i].iv, tbl[i].bp, res, lat);
                check("tbl_data", res, tbl[i].exp);
                check("tbl_latency", 128'(lat), tbl[i].bp ? 128'd1 : 128'((4 >> d) + 1));
            end
        end

        // Back-pressure in HOLD, then same-edge retire + accept
        @(negedge clk);
        st_in[0] = V_A; inv_i[0] = 1'b0; byp[0] = 1'b0; in_vld[0] = 1'b1; out_rdy[0] = 1'b0;
        check("bp_idle_rdy", 128'(in_rdy[0]), 128'd1);
        @(posedge clk);
        #1;
        in_vld[0] = 1'b0;
        n = 0;
        @(negedge clk);
        while (!out_vld[0] && n < 40) begin
            @(negedge clk);
            n++;
        end
        st_in[0] = V_B; in_vld[0] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("bp_hold_data", st_out[0], V_AM);
            check("bp_hold_vld", 128'(out_vld[0]), 128'd1);
            check("bp_hold_rdy", 128'(in_rdy[0]), 128'd0);
        end
        out_rdy[0] = 1'b1;
        #1;
        check("bp_rdy_follows", 128'(in_rdy[0]), 128'd1);
        @(posedge clk);
        #1;
        out_rdy[0] = 1'b0; in_vld[0] = 1'b0; st_in[0] = '0;
        @(negedge clk);
        check("bp_retired_vld", 128'(out_vld[0]), 128'd0);
        check("bp_next_busy", 128'(busy[0]), 128'd1);
        lat = 1;
        while (!out_vld[0] && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("bp_next_latency", 128'(lat), 128'd5);
        check("bp_next_data", st_out[0], V_BM);

        // From HOLD, take a bypass state on the retiring edge: goes straight to HOLD
        in_vld[0] = 1'b1; st_in[0] = V_C; inv_i[0] = 1'b1; byp[0] = 1'b1; out_rdy[0] = 1'b1;
        @(posedge clk);
        #1;
        in_vld[0] = 1'b0; out_rdy[0] = 1'b0; st_in[0] = '0;
        @(negedge clk);
        check("b2b_bypass_vld", 128'(out_vld[0]), 128'd1);
        check("b2b_bypass_data", st_out[0], V_C);
        out_rdy[0] = 1'b1;
        @(negedge clk);
        out_rdy[0] = 1'b0;
        check("b2b_idle", 128'(busy[0]), 128'd0);

        // Reset during the second CALC cycle
        @(negedge clk);
        st_in[0] = V_A; inv_i[0] = 1'b0; byp[0] = 1'b0; in_vld[0] = 1'b1;
        @(posedge clk);
        #1;
        in_vld[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("mid_busy", 128'(busy[0]), 128'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_vld", 128'(out_vld[0]), 128'd0);
        check("mid_rst_rdy", 128'(in_rdy[0]), 128'd1);
        check("mid_rst_busy", 128'(busy[0]), 128'd0);
        check("mid_rst_out", st_out[0], 128'd0);
        out_rdy[0] = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (out_vld[0]) seen = 1'b1;
        end
        out_rdy[0] = 1'b0;
        check("mid_no_stale", 128'(seen), 128'd0);
        xact(0, V_B, 1'b0, 1'b0, res, lat);
        check("mid_recover", res, V_BM);

        // Random round trips: ShiftRows -> Mix -> InvMix -> InvShiftRows
        for (int i = 0; i < 1000; i++) begin
            x = {$urandom, $urandom, $urandom, $urandom};
            s = shift_rows(x, 1'b0);
            xact(i % 3, s, 1'b0, 1'b0, y, lat);
            check("rnd_fwd", y, ref_mix(s, 1'b0));
            xact(i % 3, y, 1'b1, 1'b0, z, lat);
            check("rnd_inv", z, s);
            check("rnd_roundtrip", shift_rows(z, 1'b1), x);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
